// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    // Fetch sequencing: issue a read, wait out the memory, capture, present, or flush.
    typedef enum logic [2:0] {
        REQ,
        WAIT,
        DATA,
        HOLD,
        DRAIN
    } fetch_state_e;

    localparam logic [1:0]  ACCESS_WORD      = 2'b00;
    localparam logic        MEM_READ         = 1'b1;
    localparam logic [31:0] DEFAULT_START_PC = 32'h8002_0000;
    localparam logic [31:0] INSN_BYTES       = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues word reads at pc, captures the returned word,
// and presents it to decode over a valid/ready handshake. Redirects flush any
// read in flight. Optional macro FETCH_STALL_CNT_EN adds a saturating
// decode back-pressure counter on output stall_count.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] START_PC = DEFAULT_START_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_addr,
    output logic        mem_enable,
    output logic        mem_rd_wr,
    output logic [1:0]  mem_access_size,
    input  logic        mem_busy,
    input  logic [31:0] mem_data_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        insn_valid,
    input  logic        insn_ready,
    output logic [31:0] insn,
    output logic [31:0] insn_pc
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0] stall_count
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  insn_q, insn_d;
    logic [31:0]  insn_pc_q, insn_pc_d;
    logic         insn_valid_q, insn_valid_d;

    // Fetch never writes and always moves single words.
    assign mem_rd_wr       = MEM_READ;
    assign mem_access_size = ACCESS_WORD;
    assign mem_addr        = pc_q;
    // The strobe is held off while reset is asserted so nothing is issued until reset has released.
    assign mem_enable      = (state_q == REQ) && !reset;

    assign insn_valid = insn_valid_q;
    assign insn       = insn_q;
    assign insn_pc    = insn_pc_q;

    // Next-state, pc and capture logic; a redirect overrides every other transition.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        pc_d         = pc_q;
        insn_d       = insn_q;
        insn_pc_d    = insn_pc_q;
        insn_valid_d = insn_valid_q;

        case (state_q)
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_busy) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                insn_d       = mem_data_out;
                insn_pc_d    = pc_q;
                pc_d         = pc_q + INSN_BYTES;
                insn_valid_d = 1'b1;
                state_d      = HOLD;
            end
            HOLD: begin
                if (insn_valid_q && insn_ready) begin
                    insn_valid_d = 1'b0;
                    state_d      = REQ;
                end
            end
            DRAIN: begin
                if (!mem_busy) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase

        if (redirect_valid) begin
            // Any capture this cycle is dropped and pc is not advanced.
            pc_d         = redirect_pc & PC_ALIGN_MASK;
            insn_d       = insn_q;
            insn_pc_d    = insn_pc_q;
            insn_valid_d = 1'b0;
            // A read may still be outstanding from REQ/WAIT/DRAIN; flush it before refetching.
            if (state_q == REQ || state_q == WAIT || state_q == DRAIN) begin
                state_d = DRAIN;
            end else begin
                state_d = REQ;
            end
        end
    end

    // State, pc and instruction registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q      <= REQ;
            pc_q         <= START_PC;
            insn_q       <= '0;
            insn_pc_q    <= '0;
            insn_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            insn_q       <= insn_d;
            insn_pc_q    <= insn_pc_d;
            insn_valid_q <= insn_valid_d;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_count_q, stall_count_d;

    // Count cycles where decode holds off a valid instruction; saturates, survives redirects.
    always_comb begin
        stall_count_d = stall_count_q;
        if (insn_valid_q && !insn_ready && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a vector table for reset/latency/throughput,
// hand sequences for redirect, reset and wrap corners, then randomized stimulus
// checked against an instruction-stream reference model.
module tb_fetch_stage;

    localparam logic [31:0] START = 32'h8002_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr;
    logic        mem_enable;
    logic        mem_rd_wr;
    logic [1:0]  mem_access_size;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_data_out = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        insn_valid;
    logic        insn_ready;
    logic [31:0] insn;
    logic [31:0] insn_pc;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage #(.START_PC(START)) dut (
        .clk             (clk),
        .reset           (reset),
        .mem_addr        (mem_addr),
        .mem_enable      (mem_enable),
        .mem_rd_wr       (mem_rd_wr),
        .mem_access_size (mem_access_size),
        .mem_busy        (mem_busy),
        .mem_data_out    (mem_data_out),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .insn_valid      (insn_valid),
        .insn_ready      (insn_ready),
        .insn            (insn),
        .insn_pc         (insn_pc)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_count     (stall_count)
`endif
    );

    initial forever #5 clk = ~clk;

    // Memory contents: two preloaded words, everything else a fixed scramble of the address.
    function automatic logic [31:0] ref_word(input logic [31:0] a);
        if (a == 32'h8002_0000) return 32'h27BD_FFF8;
        if (a == 32'h8002_0004) return 32'hAFBF_0004;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // Memory: request accepted when idle, busy for one cycle, data valid after that.
    logic [31:0] mem_req_addr = 32'h0;
    always @(posedge clk) begin
        if (mem_busy) begin
            mem_busy     <= 1'b0;
            mem_data_out <= ref_word(mem_req_addr);
        end else if (mem_enable) begin
            mem_busy     <= 1'b1;
            mem_req_addr <= mem_addr;
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!insn_valid && n < 20) begin
            next_cycle();
            n++;
        end
        check(name, 32'(insn_valid), 32'd1);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!mem_enable && n < 20) begin
            next_cycle();
            n++;
        end
        check(name, 32'(mem_enable), 32'd1);
    endtask

    typedef struct {
        logic        ready;
        logic        en;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] insn;
        logic [31:0] ipc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] exp_stall;
        logic        was_stalled;
        int          delivered;

        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] exp_stall;
        logic        was_stalled;
        int          delivered;

        // Per-cycle expectations from reset release: REQ->valid in 3 cycles, one insn per 4.
        vecs[0] = '{1'b1, 1'b1, 32'h8002_0000, 1'b0, 32'h0,         32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h8002_0000, 1'b0, 32'h0,         32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h8002_0000, 1'b0, 32'h0,         32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h8002_0004, 1'b1, 32'h27BD_FFF8, 32'h8002_0000};
        vecs[4] = '{1'b1, 1'b1, 32'h8002_0004, 1'b0, 32'h27BD_FFF8, 32'h8002_0000};
        vecs[5] = '{1'b1, 1'b0, 32'h8002_0004, 1'b0, 32'h27BD_FFF8, 32'h8002_0000};
        vecs[6] = '{1'b1, 1'b0, 32'h8002_0004, 1'b0, 32'h27BD_FFF8, 32'h8002_0000};
        vecs[7] = '{1'b1, 1'b0, 32'h8002_0008, 1'b1, 32'hAFBF_0004, 32'h8002_0004};

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        insn_ready     = 1'b0;
        repeat (2) next_cycle();

        check("rst_en",    32'(mem_enable), 32'd0);
        check("rst_valid", 32'(insn_valid), 32'd0);
        check("rst_insn",  insn,            32'h0);
        check("rst_ipc",   insn_pc,         32'h0);
        check("rst_addr",  mem_addr,        START);
        check("rst_rdwr",  32'(mem_rd_wr),  32'd1);
        check("rst_size",  32'(mem_access_size), 32'd0);

        reset = 1'b0;
        #1;

        for (int i = 0; i < 8; i++) begin
            insn_ready = vecs[i].ready;
            check($sformatf("vec%0d_en", i),    32'(mem_enable), 32'(vecs[i].en));
            check($sformatf("vec%0d_addr", i),  mem_addr,        vecs[i].addr);
            check($sformatf("vec%0d_valid", i), 32'(insn_valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d_insn", i),  insn,            vecs[i].insn);
            check($sformatf("vec%0d_ipc", i),   insn_pc,         vecs[i].ipc);
            next_cycle();
        end

        // Back-pressure: 10 cycles with ready low leave the word frozen and issue nothing.
        insn_ready = 1'b0;
        wait_valid("stall_wait");
        for (int k = 1; k <= 10; k++) begin
            next_cycle();
            check($sformatf("stall%0d_valid", k), 32'(insn_valid), 32'd1);
            check($sformatf("stall%0d_insn", k),  insn,            ref_word(32'h8002_0008));
            check($sformatf("stall%0d_ipc", k),   insn_pc,         32'h8002_0008);
            check($sformatf("stall%0d_en", k),    32'(mem_enable), 32'd0);
        end
`ifdef FETCH_STALL_CNT_EN
        check("stall_count10", stall_count, 32'd10);
`endif
        insn_ready = 1'b1;
        next_cycle();
        insn_ready = 1'b0;

        // Redirect during WAIT: drain, then refetch from the aligned target.
        wait_req("wr_req");
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8002_0013;
        next_cycle();
        redirect_valid = 1'b0;
        check("wr_drain_en", 32'(mem_enable), 32'd0);
        wait_req("wr_req2");
        check("wr_addr", mem_addr, 32'h8002_0010);
        insn_ready = 1'b1;
        wait_valid("wr_valid");
        check("wr_ipc",  insn_pc, 32'h8002_0010);
        check("wr_insn", insn,    ref_word(32'h8002_0010));
        next_cycle();
        insn_ready = 1'b0;

        // Redirect in HOLD together with the handshake: next fetch is the target, not pc+4.
        wait_valid("hr_valid");
        check("hr_ipc", insn_pc, 32'h8002_0014);
        insn_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8002_0100;
        next_cycle();
        insn_ready     = 1'b0;
        redirect_valid = 1'b0;
        check("hr_valid_low", 32'(insn_valid), 32'd0);
        check("hr_en",   32'(mem_enable), 32'd1);
        check("hr_addr", mem_addr, 32'h8002_0100);
        wait_valid("hr_valid2");
        check("hr_ipc2",  insn_pc, 32'h8002_0100);
        check("hr_insn2", insn,    ref_word(32'h8002_0100));

        // Reset for one cycle while the memory is busy.
        insn_ready = 1'b1;
        next_cycle();
        insn_ready = 1'b0;
        wait_req("rm_req");
        next_cycle();
        check("rm_busy", 32'(mem_busy), 32'd1);
        reset = 1'b1;
        next_cycle();
        check("rm_en_in_reset", 32'(mem_enable), 32'd0);
        reset = 1'b0;
        #1;
        check("rm_valid", 32'(insn_valid), 32'd0);
        check("rm_en",    32'(mem_enable), 32'd1);
        check("rm_addr",  mem_addr,        START);
        wait_valid("rm_valid2");
        check("rm_ipc",  insn_pc, START);
        check("rm_insn", insn,    32'h27BD_FFF8);

        // Redirect to the top word (low bits set), then pc wraps to zero.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        next_cycle();
        redirect_valid = 1'b0;
        check("wrap_en",   32'(mem_enable), 32'd1);
        check("wrap_addr", mem_addr,        32'hFFFF_FFFC);
        wait_valid("wrap_valid");
        check("wrap_ipc",  insn_pc, 32'hFFFF_FFFC);
        check("wrap_insn", insn,    ref_word(32'hFFFF_FFFC));
        insn_ready = 1'b1;
        next_cycle();
        insn_ready = 1'b0;
        check("wrap_en2",   32'(mem_enable), 32'd1);
        check("wrap_addr2", mem_addr,        32'h0);

        // Randomized run against an instruction-stream model: the k-th delivered word
        // after a redirect to T must come from T+4k, and every read must target that address.
        reset          = 1'b1;
        redirect_valid = 1'b0;
        insn_ready     = 1'b0;
        repeat (2) next_cycle();
        reset = 1'b0;
        #1;
        exp_pc      = START;
        exp_stall   = 32'h0;
        was_stalled = 1'b0;
        delivered   = 0;
        for (int c = 0; c < 3000; c++) begin
            insn_ready     = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));

            check("rnd_rdwr", 32'(mem_rd_wr), 32'd1);
            check("rnd_size", 32'(mem_access_size), 32'd0);
            if (mem_enable) begin
                check("rnd_req_idle", 32'(mem_busy), 32'd0);
                check("rnd_req_addr", mem_addr, exp_pc);
            end
            if (was_stalled) check("rnd_hold_valid", 32'(insn_valid), 32'd1);
            if (insn_valid) begin
                check("rnd_ipc",  insn_pc, exp_pc);
                check("rnd_insn", insn,    ref_word(exp_pc));
            end
`ifdef FETCH_STALL_CNT_EN
            check("rnd_stall_count", stall_count, exp_stall);
`endif
            was_stalled = insn_valid && !insn_ready && !redirect_valid;
            if (insn_valid && !insn_ready && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
            if (insn_valid && insn_ready) begin
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
            next_cycle();
        end
        redirect_valid = 1'b0;
        check("rnd_progress", 32'(delivered > 150), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the unified memory model.
- Generates word-sized read requests at the program counter and waits out the memory's busy/data timing.
- Captures each returned instruction word and presents it to decode over a valid/ready handshake.
- Supports PC redirect for branches and jumps, and safely drains any read already in flight.

Parameters:
- START_PC, 32'h8002_0000, PC value loaded on reset; equals the memory base address.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_addr  output  32  byte address of the read; always equals the current pc.
- mem_enable  output  1  memory request strobe.
- mem_rd_wr  output  1  constant 1 (read); fetch never writes.
- mem_access_size  output  2  constant 2'b00 (single word).
- mem_busy  input  1  memory busy flag.
- mem_data_out  input  32  memory read data.
- redirect_valid  input  1  load a new PC this cycle.
- redirect_pc  input  32  target PC.
- insn_valid  output  1  insn/insn_pc hold a fetched instruction.
- insn_ready  input  1  decode accepts the instruction this cycle.
- insn  output  32  fetched instruction word.
- insn_pc  output  32  address insn was fetched from.

Behaviour:
- Reset values: pc=START_PC, state=REQ, mem_enable=0, insn_valid=0, insn=0, insn_pc=0.
- mem_rd_wr=1 and mem_access_size=2'b00 at all times, including during reset.
- Memory timing contract: a request sampled at edge N raises mem_busy after N. mem_data_out is valid, and mem_busy is low again, after edge N+1. The memory ignores any request sampled while mem_busy=1.
- FSM states: REQ, WAIT, DATA, HOLD, DRAIN. mem_enable is combinational and equals 1 only in REQ.
- REQ: drive mem_enable=1, mem_addr=pc. Next state is WAIT.
- WAIT: stay while mem_busy=0; go to DATA when mem_busy=1.
- DATA: on the edge, insn<=mem_data_out, insn_pc<=pc, pc<=pc+4, insn_valid<=1. Next state is HOLD.
- HOLD: hold insn, insn_pc and insn_valid stable until insn_valid&&insn_ready. On that handshake, insn_valid<=0 and the next state is REQ.
- Latency: REQ to insn_valid=1 is 3 cycles. With insn_ready held high, throughput is one instruction per 4 cycles.
- Redirect: redirect_valid has priority over every other transition in every state, including reset release +1.
- On redirect, pc<={redirect_pc[31:2],2'b00} (low bits forced to zero) and insn_valid<=0.
- Redirect destination state:
  - From REQ or WAIT, go to DRAIN (a read is in flight).
  - From DATA or HOLD, go to REQ.
  - The DATA capture is discarded; pc is not incremented.
- A redirect in the same cycle as a HOLD handshake completes the handshake (decode consumes insn), then the redirect applies.
- DRAIN: mem_enable=0. Stay while mem_busy=1; go to REQ when mem_busy=0. Returned data is discarded.
- A redirect while in DRAIN updates pc and stays in DRAIN.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0. No fault is raised.
- Reset asserted mid-read: state returns to REQ and the in-flight read is abandoned. The memory's own busy pulse clears by itself; the memory has no reset. The first request after reset is issued no earlier than one cycle after reset deasserts.

Optional Feature:
- Macro: FETCH_STALL_CNT_EN.
- When defined: adds output port stall_count (32 bits). It increments each cycle insn_valid=1 && insn_ready=0, saturates at 32'hFFFF_FFFF, and resets to 0. It is not cleared by redirect.
- When undefined: the port and the counter are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg holds:
  - the FSM state enum (REQ, WAIT, DATA, HOLD, DRAIN);
  - ACCESS_WORD=2'b00;
  - MEM_READ=1'b1;
  - DEFAULT_START_PC=32'h8002_0000;
  - INSN_BYTES=4.
- No sub-module; the FSM, PC register and output registers live in one module.

Test Plan:
- Preload mem[0x80020000]=0x27BDFFF8, mem[0x80020004]=0xAFBF0004; hold insn_ready=1 after reset -> insn=0x27BDFFF8, insn_pc=0x80020000 three cycles after the first REQ, then insn=0xAFBF0004, insn_pc=0x80020004 four cycles later.
- Hold insn_ready=0 for 10 cycles after insn_valid rises -> insn, insn_pc and insn_valid stay constant and no new mem_enable pulse appears. With FETCH_STALL_CNT_EN, stall_count=10.
- Pulse redirect_valid with redirect_pc=0x80020013 during WAIT -> DRAIN until mem_busy=0, then a REQ with mem_addr=0x80020010. The stale word is never presented.
- Pulse redirect_valid in HOLD together with insn_ready=1 -> current insn is consumed, then the next fetch comes from redirect_pc; the pc+4 address is never fetched.
- Assert reset for 1 cycle while mem_busy=1 -> insn_valid=0, the first new mem_addr is 0x80020000, and fetch proceeds normally.
- Redirect to 0xFFFFFFFC with a stub memory -> after that fetch, the next mem_addr is 0x00000000.
